nwc_result_collector: RTL and testbench

Receiving end of the `nwc_processor` result stream. The block captures one complete result frame: `WORDS` packed 60-bit words, each holding two 30-bit coefficients, presented on `output_active`/`data_out`. It buffers the frame, then replays it to a downstream consumer as a valid/ready stream of single coefficients in natural order: word k bits [29:0] first, then bits [59:30]. It sits between the processor output and the host-side readback path.

---
 rtl/nwc_pkg.sv | 16 +
 rtl/nwc_result_buffer.sv | 35 +++
 rtl/nwc_result_collector.sv | 176 +++++++++++++++++
 tb/tb_nwc_result_collector.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nwc_pkg.sv
// Shared constants, packed-word type and FSM encoding for the NWC result
// collector.
package nwc_pkg;

  localparam int NWC_COEFF_WIDTH = 30;
  localparam int NWC_WORDS       = 2048;

  typedef logic [2*NWC_COEFF_WIDTH-1:0] nwc_word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } collector_state_t;

endpackage

// File: rtl/nwc_result_buffer.sv
// Simple dual-port frame buffer: one write port, one read port with a
// registered single-cycle read. The array is never reset.
module nwc_result_buffer #(
  parameter int WIDTH = 60,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // rd_data only changes on a read, so it doubles as the prefetch holding slot.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/nwc_result_collector.sv
// Captures one frame of packed result words, then replays it as a valid/ready
// stream of single coefficients (low half of each word first).
module nwc_result_collector
  import nwc_pkg::*;
#(
  parameter int COEFF_WIDTH = NWC_COEFF_WIDTH,
  parameter int WORDS       = NWC_WORDS,
  parameter int ADDR_WIDTH  = $clog2(WORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2*COEFF_WIDTH-1:0] data_in,
  input  logic                     in_active,
  output logic [COEFF_WIDTH-1:0]   m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done,
  output logic                     overflow
);

  localparam int              AW        = (ADDR_WIDTH < 1) ? 1 : ADDR_WIDTH;
  localparam int              DW        = 2 * COEFF_WIDTH;
  localparam logic [AW-1:0]   LAST_ADDR = AW'(WORDS - 1);
  localparam logic [AW:0]     RD_END    = (AW + 1)'(WORDS);

  collector_state_t state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             rd_pend_q, rd_pend_d;
  logic [DW-1:0]    word_q, word_d;
  logic [AW-1:0]    word_idx_q, word_idx_d;
  logic             half_q, half_d;
  logic             m_valid_q, m_valid_d;
  logic             done_q, done_d;
  logic             overflow_q, overflow_d;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [DW-1:0]    rd_data;
  logic             hs;
  logic             slot_free;
  logic             load;

  nwc_result_buffer #(
    .WIDTH (DW),
    .DEPTH (WORDS),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign hs        = m_valid_q && m_ready;
  // The output word slot frees up when empty or when its high half is taken.
  assign slot_free = !m_valid_q || (m_ready && half_q);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = rd_pend_q;
    word_d     = word_q;
    word_idx_d = word_idx_q;
    half_d     = half_q;
    m_valid_d  = m_valid_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    wr_addr    = wr_ptr_q;
    rd_en      = 1'b0;
    rd_addr    = rd_ptr_q[AW-1:0];
    load       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_active) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_ptr_d = AW'(1);
          state_d  = (WORDS == 1) ? ST_DRAIN : ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (in_active) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (in_active) begin
          overflow_d = 1'b1;
        end
        if (hs && !half_q) begin
          half_d = 1'b1;
        end
        if (hs && half_q) begin
          m_valid_d = 1'b0;
        end
        if (hs && half_q && (word_idx_q == LAST_ADDR)) begin
          done_d     = 1'b1;
          state_d    = ST_IDLE;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          rd_pend_d  = 1'b0;
          word_idx_d = '0;
          half_d     = 1'b0;
        end else if (slot_free && rd_pend_q) begin
          load       = 1'b1;
          word_d     = rd_data;
          word_idx_d = rd_ptr_q[AW-1:0] - 1'b1;
          m_valid_d  = 1'b1;
          half_d     = 1'b0;
          rd_pend_d  = 1'b0;
        end
        // Refill the prefetch slot whenever it is empty or being consumed.
        if ((rd_ptr_q < RD_END) && (!rd_pend_q || load)) begin
          rd_en     = 1'b1;
          rd_ptr_d  = rd_ptr_q + 1'b1;
          rd_pend_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_pend_q  <= 1'b0;
      word_q     <= '0;
      word_idx_q <= '0;
      half_q     <= 1'b0;
      m_valid_q  <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_pend_q  <= rd_pend_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      half_q     <= half_d;
      m_valid_q  <= m_valid_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign m_data   = half_q ? word_q[DW-1:COEFF_WIDTH] : word_q[COEFF_WIDTH-1:0];
  assign m_valid  = m_valid_q;
  assign m_last   = m_valid_q && half_q && (word_idx_q == LAST_ADDR);
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_nwc_result_collector.sv
// Scoreboard bench for nwc_result_collector: frames are turned into expected
// coefficient lists when sent, and a monitor checks every handshake.
module tb_nwc_result_collector;
  import nwc_pkg::*;

  localparam int CW    = NWC_COEFF_WIDTH;
  localparam int WORDS = NWC_WORDS;
  localparam int NCOEF = 2 * WORDS;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  nwc_word_t     data_in   = '0;
  logic          in_active = 1'b0;
  logic [CW-1:0] m_data;
  logic          m_valid;
  logic          m_ready   = 1'b1;
  logic          m_last;
  logic          busy;
  logic          done;
  logic          overflow;

  typedef struct packed {
    logic [CW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks        = 0;
  int            errors        = 0;
  int            hs_count      = 0;
  int            done_count    = 0;
  logic          exp_ovf       = 1'b0;
  bit            exp_done_next = 1'b0;
  bit            rand_ready    = 1'b0;
  bit            prev_stall    = 1'b0;
  logic [CW-1:0] prev_data     = '0;
  logic          prev_last     = 1'b0;

  always #5 clk = ~clk;

  nwc_result_collector dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .in_active (in_active),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Consumer: ready changes just after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: inspects the settled outputs at the falling edge; a handshake
  // seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall    = 1'b0;
      exp_done_next = 1'b0;
    end else begin
      if (exp_done_next || done) begin
        check("done_pulse", done, exp_done_next);
        if (exp_done_next) begin
          check("busy_in_done", busy, 0);
          done_count++;
        end
      end
      exp_done_next = 1'b0;
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", m_data, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_coeff: got %0d, expected no output", m_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("coeff", m_data, mon_e.data);
          check("last", m_last, mon_e.last);
          if (mon_e.last) exp_done_next = 1'b1;
        end
        check("overflow", overflow, exp_ovf);
        hs_count++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  // mode 0: word k = {base+2k+1, base+2k}; mode 1: random halves.
  // gap 0: none, 1: idle cycle after every word, 2: random idle cycles.
  task automatic send_frame(input int mode, input int base, input int gap);
    logic [CW-1:0] lo;
    logic [CW-1:0] hi;
    for (int k = 0; k < WORDS; k++) begin
      if (mode == 0) begin
        lo = CW'(base + 2 * k);
        hi = CW'(base + 2 * k + 1);
      end else begin
        lo = CW'($urandom);
        hi = CW'($urandom);
      end
      exp_q.push_back('{data: lo, last: 1'b0});
      exp_q.push_back('{data: hi, last: (k == WORDS - 1)});
      data_in   = {hi, lo};
      in_active = 1'b1;
      @(posedge clk);
      #1;
      in_active = 1'b0;
      if (k != WORDS - 1) begin
        if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    check("lat_edge0_valid", m_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge1_valid", m_valid, 0);
    @(posedge clk);
    #1;
    check("lat_edge2_valid", m_valid, 1);
  endtask

  task automatic wait_frame(input int start_done, input int start_hs, input int n_hs);
    int n = 0;
    while (done_count == start_done && n < 30000) begin
      @(posedge clk);
      n++;
    end
    check("frame_completed", done_count != start_done, 1);
    @(negedge clk);
    #1;
    check("handshake_total", hs_count - start_hs, n_hs);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 30000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("hs_reached", hs_count >= target, 1);
  endtask

  initial begin
    int d0;
    int h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_m_data", m_data, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Continuous full frame
    d0 = done_count; h0 = hs_count;
    send_frame(0, 0, 0);
    wait_frame(d0, h0, NCOEF);
    check("cont_overflow", overflow, 0);

    // Alternating gaps
    d0 = done_count; h0 = hs_count;
    send_frame(0, 0, 1);
    wait_frame(d0, h0, NCOEF);

    // Random data, random gaps, random back-pressure
    rand_ready = 1'b1;
    d0 = done_count; h0 = hs_count;
    send_frame(1, 0, 2);
    wait_frame(d0, h0, NCOEF);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // Stray word during DRAIN
    d0 = done_count; h0 = hs_count;
    send_frame(0, 0, 0);
    wait_hs(h0 + 100);
    data_in   = {CW'($urandom), CW'($urandom)};
    in_active = 1'b1;
    @(posedge clk);
    #1;
    in_active = 1'b0;
    exp_ovf   = 1'b1;
    check("ovf_set", overflow, 1);
    wait_frame(d0, h0, NCOEF);
    check("ovf_sticky", overflow, 1);

    // Reset in the middle of DRAIN
    h0 = hs_count;
    send_frame(0, 0, 0);
    wait_hs(h0 + 1000);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_last", m_last, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_overflow", overflow, 0);
    check("mid_rst_m_data", m_data, 0);
    exp_q.delete();
    exp_ovf = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh frame after reset
    d0 = done_count; h0 = hs_count;
    send_frame(0, 5000, 0);
    wait_frame(d0, h0, NCOEF);

    // Back-to-back: second frame starts in the done cycle
    d0 = done_count; h0 = hs_count;
    send_frame(0, 0, 0);
    begin
      int n = 0;
      while (!done && n < 30000) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("b2b_done_seen", done, 1);
    check("b2b_idle_in_done", busy, 0);
    send_frame(1, 0, 0);
    wait_frame(d0 + 1, h0, 2 * NCOEF);
    check("final_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
